// File: rtl/uart_proto_pkg.sv
// Shared host-link UART protocol definitions: frame byte constants, the
// transmit FSM state encoding and the default image geometry.
package uart_proto_pkg;

   localparam logic [7:0] START_BYTE = 8'hFF;
   localparam logic [7:0] TRAIN_BYTE = 8'hF0;
   localparam logic [7:0] TEST_BYTE  = 8'h0F;

   localparam int unsigned DEFAULT_NPIX = 784;

   typedef enum logic [2:0] {
      TX_IDLE  = 3'd0,
      TX_START = 3'd1,
      TX_MODE  = 3'd2,
      TX_LABEL = 3'd3,
      TX_DATA  = 3'd4,
      TX_CHECK = 3'd5
   } tx_state_e;

   function automatic logic [7:0] mode_byte(input logic train);
      return train ? TRAIN_BYTE : TEST_BYTE;
   endfunction

endpackage

// File: rtl/uart_packet_tx_if.sv
// Byte-level valid/ready link between the frame transmitter (master) and the
// UART TX serializer (slave).
interface uart_packet_tx_if;

   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_byte;

   modport master (output tx_valid, output tx_byte, input tx_ready);
   modport slave  (input tx_valid, input tx_byte, output tx_ready);

endinterface

// File: rtl/ones_comp_add.sv
// 8-bit one's-complement adder with end-around carry; shared by the frame
// transmitter and the receive-path checksum.
module ones_comp_add (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);

   logic [8:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};
   // a+b never exceeds 0x1FE, so folding the carry back in cannot overflow again.
   assign y   = sum[7:0] + {7'd0, sum[8]};

endmodule

// File: rtl/uart_packet_tx.sv
// Host-link frame transmitter: START, mode, label, NPIX pixel bytes, checksum.
// Define UART_CHECKSUM_EN to send the one's-complement checksum; otherwise 0x00.
module uart_packet_tx
   import uart_proto_pkg::*;
#(
   parameter int unsigned IMG_SZ = DEFAULT_NPIX << 3
) (
   input  logic              uart_sampling_clk,
   input  logic              rst,
   input  logic              send,
   input  logic              resend,
   input  logic              train,
   input  logic [7:0]        label,
   input  logic [IMG_SZ-1:0] image,
   output logic              busy,
   output logic              done,
   output logic [2:0]        cs_out,
   uart_packet_tx_if.master  tx_if
);

   localparam int unsigned      NPIX     = IMG_SZ / 8;
   localparam int unsigned      IDX_W    = 10;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

   tx_state_e         state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
   logic              train_q, train_d;
   logic [7:0]        label_q, label_d;
   logic [IMG_SZ-1:0] image_q, image_d;
   logic              captured_q, captured_d;
   logic              tx_valid_q, tx_valid_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic              done_q, done_d;

   logic              accept;
   logic [7:0]        cur_pix;
   logic [7:0]        nxt_pix;
   logic [7:0]        check_byte;

   assign accept  = tx_valid_q && tx_if.tx_ready;
   assign idx_inc = idx_q + IDX_W'(1);
   assign cur_pix = image_q[{idx_q, 3'b000} +: 8];
   assign nxt_pix = image_q[{idx_inc, 3'b000} +: 8];

`ifdef UART_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
   logic [7:0] csum_add;
   logic [7:0] csum_sum;

   assign csum_add = (state_q == TX_LABEL) ? label_q : cur_pix;

   ones_comp_add u_csum_add (
      .a (csum_q),
      .b (csum_add),
      .y (csum_sum)
   );

   // Held at zero while idle, so every frame starts accumulating from 0x00.
   always_comb begin
      csum_d = csum_q;
      if (state_q == TX_IDLE) begin
         csum_d = '0;
      end else if (accept && (state_q == TX_LABEL || state_q == TX_DATA)) begin
         csum_d = csum_sum;
      end
   end

   always_ff @(posedge uart_sampling_clk or posedge rst) begin
      if (rst) csum_q <= '0;
      else     csum_q <= csum_d;
   end

   // On the last DATA accept the sum already includes the final pixel.
   assign check_byte = csum_sum;
`else
   assign check_byte = 8'h00;
`endif

   // NOTE: every variable gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      train_d    = train_q;
      label_d    = label_q;
      image_d    = image_q;
      captured_d = captured_q;
      tx_valid_d = tx_valid_q;
      tx_byte_d  = tx_byte_q;
      done_d     = 1'b0;

      unique case (state_q)
         TX_IDLE: begin
            if (send || (resend && captured_q)) begin
               if (send) begin
                  train_d    = train;
                  label_d    = label;
                  image_d    = image;
                  captured_d = 1'b1;
               end
               idx_d      = '0;
               state_d    = TX_START;
               tx_valid_d = 1'b1;
               tx_byte_d  = START_BYTE;
            end
         end
         TX_START: begin
            if (accept) begin
               state_d   = TX_MODE;
               tx_byte_d = mode_byte(train_q);
            end
         end
         TX_MODE: begin
            if (accept) begin
               state_d   = TX_LABEL;
               tx_byte_d = label_q;
            end
         end
         TX_LABEL: begin
            if (accept) begin
               state_d   = TX_DATA;
               tx_byte_d = cur_pix;
            end
         end
         TX_DATA: begin
            if (accept) begin
               if (idx_q == LAST_IDX) begin
                  state_d   = TX_CHECK;
                  tx_byte_d = check_byte;
               end else begin
                  idx_d     = idx_inc;
                  tx_byte_d = nxt_pix;
               end
            end
         end
         TX_CHECK: begin
            if (accept) begin
               state_d    = TX_IDLE;
               tx_valid_d = 1'b0;
               tx_byte_d  = 8'h00;
               done_d     = 1'b1;
            end
         end
         default: begin
            state_d    = TX_IDLE;
            tx_valid_d = 1'b0;
            tx_byte_d  = 8'h00;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge uart_sampling_clk or posedge rst) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         idx_q      <= '0;
         train_q    <= 1'b0;
         label_q    <= '0;
         captured_q <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_byte_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         train_q    <= train_d;
         label_q    <= label_d;
         captured_q <= captured_d;
         tx_valid_q <= tx_valid_d;
         tx_byte_q  <= tx_byte_d;
         done_q     <= done_d;
      end
   end

   // NOTE: the image store is not reset; captured_q alone says whether its contents are valid.
   always_ff @(posedge uart_sampling_clk) begin
      image_q <= image_d;
   end

   assign tx_if.tx_valid = tx_valid_q;
   assign tx_if.tx_byte  = tx_byte_q;
   assign busy           = (state_q != TX_IDLE);
   assign done           = done_q;
   assign cs_out         = state_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Self-checking bench for uart_packet_tx: randomized data and tx_ready stalls
// compared against a frame-level reference model built from the protocol rules.
module tb_uart_packet_tx;

   localparam int IMG_SZ = 784 * 8;
   localparam int NPIX   = IMG_SZ / 8;
   localparam int FLEN   = NPIX + 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              send;
   logic              resend;
   logic              train_i;
   logic [7:0]        label_i;
   logic [IMG_SZ-1:0] image_i;
   logic              tx_ready;
   logic              tx_valid;
   logic [7:0]        tx_byte;
   logic              busy;
   logic              done;
   logic [2:0]        cs_out;

   uart_packet_tx_if tx_if ();

   assign tx_if.tx_ready = tx_ready;
   assign tx_valid       = tx_if.tx_valid;
   assign tx_byte        = tx_if.tx_byte;

   uart_packet_tx #(.IMG_SZ(IMG_SZ)) dut (
      .uart_sampling_clk (clk),
      .rst               (rst),
      .send              (send),
      .resend            (resend),
      .train             (train_i),
      .label             (label_i),
      .image             (image_i),
      .busy              (busy),
      .done              (done),
      .cs_out            (cs_out),
      .tx_if             (tx_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
      end
   endtask

   // Reference model: the complete expected frame as a byte queue.
   logic [7:0] exp_q[$];

   function automatic void build_frame(input bit tr, input logic [7:0] lb,
                                       input logic [IMG_SZ-1:0] img);
      int s;
      logic [7:0] b;
      exp_q.delete();
      exp_q.push_back(8'hFF);
      exp_q.push_back(tr ? 8'hF0 : 8'h0F);
      exp_q.push_back(lb);
      s = lb;
      for (int k = 0; k < NPIX; k++) begin
         b = img[8*k +: 8];
         exp_q.push_back(b);
         s = s + b;
         if (s > 255) s = s - 255;
      end
`ifdef UART_CHECKSUM_EN
      exp_q.push_back(s[7:0]);
`else
      exp_q.push_back(8'h00);
`endif
   endfunction

   // Monitor: collects accepted bytes, done pulses and checks stall stability.
   logic [7:0] got[$];
   int   cyc          = 0;
   int   first_acc    = -1;
   int   last_acc     = -1;
   int   done_cyc     = -1;
   int   done_cnt     = 0;
   int   valid_cycles = 0;
   bit   prev_stall   = 1'b0;
   logic [7:0] prev_byte = 8'h00;

   always @(negedge clk) begin
      cyc++;
      if (tx_valid === 1'b1) valid_cycles++;
      if (tx_valid === 1'b1 && tx_ready) begin
         if (first_acc < 0) first_acc = cyc;
         last_acc = cyc;
         got.push_back(tx_byte);
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
         check("done_busy_low", {31'd0, busy}, 32'd0);
         check("done_valid_low", {31'd0, tx_valid}, 32'd0);
      end
      if (!rst && prev_stall) begin
         check("stall_valid_held", {31'd0, tx_valid}, 32'd1);
         check("stall_byte_held", {24'd0, tx_byte}, {24'd0, prev_byte});
      end
      prev_stall = !rst && (tx_valid === 1'b1) && !tx_ready;
      prev_byte  = tx_byte;
   end

   task automatic clear_mon();
      got.delete();
      first_acc    = -1;
      last_acc     = -1;
      done_cyc     = -1;
      done_cnt     = 0;
      valid_cycles = 0;
   endtask

   function automatic logic pick_ready(input bit stall);
      return stall ? ($urandom_range(0, 2) != 0) : 1'b1;
   endfunction

   task automatic compare_frame(input string tag);
      int f0;
      f0 = n_fail;
      check({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
         if (n_fail > f0 + 4) break;
      end
   endtask

   // Issue send/resend, run one frame to completion and check it against exp_q.
   task automatic run_frame(input bit use_send, input bit stall, input bit inject_send,
                            input string tag);
      clear_mon();
      if (use_send) send = 1'b1;
      else          resend = 1'b1;
      tx_ready = pick_ready(stall);
      @(posedge clk); #1;
      send   = 1'b0;
      resend = 1'b0;
      check({tag, "_lat_valid"}, {31'd0, tx_valid}, 32'd1);
      check({tag, "_lat_byte"}, {24'd0, tx_byte}, 32'hFF);
      check({tag, "_lat_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_lat_cs"}, {29'd0, cs_out}, 32'd1);
      for (int c = 0; c < 6000; c++) begin
         if (done_cnt != 0) break;
         if (inject_send && c == 40) begin
            send    = 1'b1;
            train_i = ~train_i;
            label_i = ~label_i;
            image_i = ~image_i;
         end
         tx_ready = pick_ready(stall);
         @(posedge clk); #1;
         send = 1'b0;
      end
      check({tag, "_done_seen"}, {31'd0, done_cnt != 0}, 32'd1);
      tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_done_once"}, done_cnt, 32'd1);
      check({tag, "_idle_cs"}, {29'd0, cs_out}, 32'd0);
      compare_frame(tag);
      if (!stall) begin
         check({tag, "_throughput"}, last_acc - first_acc + 1, FLEN);
         check({tag, "_done_lat"}, done_cyc - last_acc, 32'd1);
      end
   endtask

   task automatic randomize_inputs();
      train_i = 1'($urandom_range(0, 1));
      label_i = 8'($urandom_range(0, 255));
      for (int k = 0; k < NPIX; k++) image_i[8*k +: 8] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b0;
      send     = 1'b0;
      resend   = 1'b0;
      tx_ready = 1'b0;
      train_i  = 1'b0;
      label_i  = 8'h00;
      image_i  = '0;
      #2 rst = 1'b1;
      #1;
      check("rst_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_byte", {24'd0, tx_byte}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_cs", {29'd0, cs_out}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_cs", {29'd0, cs_out}, 32'd0);

      // resend with nothing captured since reset is ignored
      clear_mon();
      tx_ready = 1'b1;
      resend   = 1'b1;
      @(posedge clk); #1;
      resend = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("early_resend_valid", valid_cycles, 32'd0);
      check("early_resend_cs", {29'd0, cs_out}, 32'd0);

      // counting pixels, train mode, no stalls
      train_i = 1'b1;
      label_i = 8'h05;
      for (int k = 0; k < NPIX; k++) image_i[8*k +: 8] = 8'(k);
      build_frame(train_i, label_i, image_i);
      run_frame(1'b1, 1'b0, 1'b0, "count");

      // all-ones frame in test mode
      train_i = 1'b0;
      label_i = 8'hFF;
      image_i = '1;
      build_frame(train_i, label_i, image_i);
      run_frame(1'b1, 1'b0, 1'b0, "ones");
      if (got.size() == FLEN) begin
         check("ones_mode_byte", {24'd0, got[1]}, 32'h0F);
`ifdef UART_CHECKSUM_EN
         check("ones_checksum", {24'd0, got[FLEN-1]}, 32'hFF);
`else
         check("ones_checksum", {24'd0, got[FLEN-1]}, 32'h00);
`endif
      end

      // random data, random stalls, send pulsed while busy
      randomize_inputs();
      build_frame(train_i, label_i, image_i);
      run_frame(1'b1, 1'b1, 1'b1, "stall");

      // inputs change, then resend must replay the captured frame
      randomize_inputs();
      run_frame(1'b0, 1'b1, 1'b0, "resend");

      // asynchronous reset during DATA at idx 100
      randomize_inputs();
      build_frame(train_i, label_i, image_i);
      clear_mon();
      tx_ready = 1'b1;
      send     = 1'b1;
      @(posedge clk); #1;
      send = 1'b0;
      for (int c = 0; c < 400 && got.size() < 103; c++) begin
         @(posedge clk); #1;
      end
      check("midrst_reached", got.size(), 32'd103);
      check("midrst_pre_cs", {29'd0, cs_out}, 32'd4);
      check("midrst_pre_byte", {24'd0, tx_byte}, {24'd0, exp_q[103]});
      rst = 1'b1;
      #1;
      check("midrst_valid", {31'd0, tx_valid}, 32'd0);
      check("midrst_cs", {29'd0, cs_out}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("midrst_no_done", done_cnt, 32'd0);
      clear_mon();
      resend = 1'b1;
      @(posedge clk); #1;
      resend = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("midrst_resend_valid", valid_cycles, 32'd0);
      check("midrst_resend_done", done_cnt, 32'd0);
      check("midrst_resend_cs", {29'd0, cs_out}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
